// File: rtl/tremolo_lfo.sv
// Stereo tremolo: an internal LFO scales a left/right sample stream through a
// two-stage valid-qualified pipeline. LFO rate, depth and shape are runtime-programmable.
module tremolo_lfo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DIV_W  = 24
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              enable,
   input  logic [DIV_W-1:0]  rate_div,
   input  logic [7:0]        depth,
   input  logic [1:0]        shape,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_left,
   input  logic [DATA_W-1:0] in_right,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_left,
   output logic [DATA_W-1:0] out_right,
   output logic [7:0]        lfo_level
);

   localparam int unsigned ProdW = DATA_W + 10;

   // LFO state
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [7:0]       phase_q, phase_d;

   // Stage 1
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_left_q, s1_left_d;
   logic [DATA_W-1:0] s1_right_q, s1_right_d;
   logic [8:0]        s1_gain_q, s1_gain_d;

   // Stage 2
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_left_q, out_left_d;
   logic [DATA_W-1:0] out_right_q, out_right_d;

   logic [7:0]        lfo_l;
   logic [7:0]        inv_l;
   logic [15:0]       mod_prod;
   logic [8:0]        gain;
   logic signed [ProdW-1:0] prod_l;
   logic signed [ProdW-1:0] prod_r;

   // Divider: a count at or above rate_div ticks immediately, so shrinking
   // rate_div mid-period ticks on the next cycle.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (!enable) begin
         cnt_d   = '0;
         phase_d = '0;
      end else if (cnt_q >= rate_div) begin
         cnt_d   = '0;
         phase_d = phase_q + 8'd1;
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   // For phase >= 128, 255 - phase equals ~phase with the MSB clear.
   always_comb begin
      lfo_l = '0;
      unique case (shape)
         2'b01:        lfo_l = phase_q[7] ? 8'd0 : 8'd255;
         2'b10:        lfo_l = ~phase_q;
         2'b00, 2'b11: lfo_l = phase_q[7] ? {~phase_q[6:0], 1'b0} : {phase_q[6:0], 1'b0};
         default:      lfo_l = '0;
      endcase
   end

   assign lfo_level = lfo_l;

   always_comb begin
      inv_l    = 8'd255 - lfo_l;
      mod_prod = {8'd0, depth} * {8'd0, inv_l};
      if (enable) begin
         gain = 9'd256 - 9'(mod_prod >> 8);
      end else begin
         gain = 9'd256;
      end
   end

   always_comb begin
      s1_valid_d = in_valid;
      s1_left_d  = s1_left_q;
      s1_right_d = s1_right_q;
      s1_gain_d  = s1_gain_q;
      if (in_valid) begin
         s1_left_d  = in_left;
         s1_right_d = in_right;
         s1_gain_d  = gain;
      end
   end

   // Gain is zero-extended, so it stays positive in the signed product;
   // the arithmetic shift floors toward minus infinity.
   always_comb begin
      prod_l = $signed({{10{s1_left_q[DATA_W-1]}}, s1_left_q})
             * $signed({{(DATA_W + 1){1'b0}}, s1_gain_q});
      prod_r = $signed({{10{s1_right_q[DATA_W-1]}}, s1_right_q})
             * $signed({{(DATA_W + 1){1'b0}}, s1_gain_q});
      out_valid_d = s1_valid_q;
      out_left_d  = out_left_q;
      out_right_d = out_right_q;
      if (s1_valid_q) begin
         out_left_d  = DATA_W'(prod_l >>> 8);
         out_right_d = DATA_W'(prod_r >>> 8);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q       <= '0;
         phase_q     <= '0;
         s1_valid_q  <= 1'b0;
         s1_left_q   <= '0;
         s1_right_q  <= '0;
         s1_gain_q   <= '0;
         out_valid_q <= 1'b0;
         out_left_q  <= '0;
         out_right_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         s1_valid_q  <= s1_valid_d;
         s1_left_q   <= s1_left_d;
         s1_right_q  <= s1_right_d;
         s1_gain_q   <= s1_gain_d;
         out_valid_q <= out_valid_d;
         out_left_q  <= out_left_d;
         out_right_q <= out_right_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_left  = out_left_q;
   assign out_right = out_right_q;

endmodule

// File: tb/tb_tremolo_lfo.sv
// Directed self-checking bench for tremolo_lfo: gain, LFO shapes, divider
// timing, streaming and asynchronous reset.
module tb_tremolo_lfo;

   localparam int DATA_W = 16;
   localparam int DIV_W  = 24;

   logic              CLK;
   logic              RST_N;
   logic              enable;
   logic [DIV_W-1:0]  rate_div;
   logic [7:0]        depth;
   logic [1:0]        shape;
   logic              in_valid;
   logic [DATA_W-1:0] in_left;
   logic [DATA_W-1:0] in_right;
   logic              out_valid;
   logic [DATA_W-1:0] out_left;
   logic [DATA_W-1:0] out_right;
   logic [7:0]        lfo_level;

   int n_checks = 0;
   int n_pass   = 0;

   tremolo_lfo #(
      .DATA_W (DATA_W),
      .DIV_W  (DIV_W)
   ) u_dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .enable    (enable),
      .rate_div  (rate_div),
      .depth     (depth),
      .shape     (shape),
      .in_valid  (in_valid),
      .in_left   (in_left),
      .in_right  (in_right),
      .out_valid (out_valid),
      .out_left  (out_left),
      .out_right (out_right),
      .lfo_level (lfo_level)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input int l, input int r);
      in_valid = 1'b1;
      in_left  = 16'(l);
      in_right = 16'(r);
   endtask

   initial begin
      RST_N    = 1'b1;
      enable   = 1'b0;
      rate_div = '0;
      depth    = '0;
      shape    = 2'b00;
      in_valid = 1'b0;
      in_left  = '0;
      in_right = '0;
      #2 RST_N = 1'b0;
      repeat (2) step();
      check("rst_valid", int'(out_valid), 0);
      check("rst_left", $signed(out_left), 0);
      check("rst_right", $signed(out_right), 0);
      check("rst_level", int'(lfo_level), 0);
      RST_N = 1'b1;
      step();

      // 1: depth 0 is unity gain, two-cycle latency, single pulse, hold
      enable   = 1'b1;
      depth    = 8'd0;
      rate_div = 24'd1000;
      send(16384, -16384);
      step();
      in_valid = 1'b0;
      check("t1_lat1_valid", int'(out_valid), 0);
      step();
      check("t1_valid", int'(out_valid), 1);
      check("t1_left", $signed(out_left), 16384);
      check("t1_right", $signed(out_right), -16384);
      step();
      check("t1_pulse_end", int'(out_valid), 0);
      check("t1_hold_left", $signed(out_left), 16384);

      // 2: triangle, rate_div 3, full depth
      enable = 1'b0;
      step();
      shape    = 2'b00;
      rate_div = 24'd3;
      depth    = 8'd255;
      enable   = 1'b1;
      check("t2_level_p0", int'(lfo_level), 0);
      send(1000, -1000);
      step();
      in_valid = 1'b0;
      step();
      check("t2_g2_valid", int'(out_valid), 1);
      check("t2_g2_left", $signed(out_left), 7);
      check("t2_g2_right", $signed(out_right), -8);
      repeat (2) step();
      check("t2_level_p1", int'(lfo_level), 2);
      for (int p = 2; p <= 256; p++) begin
         repeat (4) step();
         if (p == 2)   check("t2_level_p2", int'(lfo_level), 4);
         if (p == 127) check("t2_level_p127", int'(lfo_level), 254);
         if (p == 128) check("t2_level_p128", int'(lfo_level), 254);
         if (p == 255) check("t2_level_p255", int'(lfo_level), 0);
         if (p == 256) check("t2_level_wrap", int'(lfo_level), 0);
      end
      repeat (4) step();
      check("t2_level_wrap_p1", int'(lfo_level), 2);

      // 3: square, depth 128, back-to-back pairs in the low half
      enable = 1'b0;
      step();
      shape    = 2'b01;
      depth    = 8'd128;
      rate_div = 24'd1000;
      enable   = 1'b1;
      check("t3_level_hi", int'(lfo_level), 255);
      send(-32768, 100);
      step();
      in_valid = 1'b0;
      step();
      check("t3_g256_left", $signed(out_left), -32768);
      check("t3_g256_right", $signed(out_right), 100);
      rate_div = 24'd0;
      repeat (128) step();
      rate_div = 24'd1000;
      check("t3_level_lo", int'(lfo_level), 0);
      send(-32768, 32767);
      step();
      send(-1, 255);
      step();
      check("t3_b2b_valid0", int'(out_valid), 1);
      check("t3_neg_full_l", $signed(out_left), -16512);
      check("t3_pos_full_r", $signed(out_right), 16511);
      send(1, -256);
      step();
      check("t3_b2b_valid1", int'(out_valid), 1);
      check("t3_minus1_l", $signed(out_left), -1);
      check("t3_255_r", $signed(out_right), 128);
      in_valid = 1'b0;
      step();
      check("t3_b2b_valid2", int'(out_valid), 1);
      check("t3_plus1_l", $signed(out_left), 0);
      check("t3_m256_r", $signed(out_right), -129);
      step();
      check("t3_idle", int'(out_valid), 0);

      // 4: ten-cycle stream, depth 0
      depth = 8'd0;
      for (int k = 0; k < 12; k++) begin
         if (k < 10) send(k, -k);
         else in_valid = 1'b0;
         step();
         if (k == 0 || k == 11) begin
            check($sformatf("t4_valid_n%0d", k + 1), int'(out_valid), 0);
         end else begin
            check($sformatf("t4_valid_n%0d", k + 1), int'(out_valid), 1);
            check($sformatf("t4_left_n%0d", k + 1), $signed(out_left), k - 1);
            check($sformatf("t4_right_n%0d", k + 1), $signed(out_right), 1 - k);
         end
      end

      // 5: lowering rate_div below the current count
      enable = 1'b0;
      step();
      shape    = 2'b00;
      depth    = 8'd255;
      rate_div = 24'd100;
      enable   = 1'b1;
      repeat (50) step();
      check("t5_no_tick", int'(lfo_level), 0);
      rate_div = 24'd5;
      step();
      check("t5_tick_next", int'(lfo_level), 2);
      repeat (5) step();
      check("t5_period_hold", int'(lfo_level), 2);
      step();
      check("t5_period_tick", int'(lfo_level), 4);
      enable = 1'b0;
      step();
      check("t5_dis_level", int'(lfo_level), 0);
      send(12345, -777);
      step();
      in_valid = 1'b0;
      step();
      check("t5_dis_valid", int'(out_valid), 1);
      check("t5_dis_left", $signed(out_left), 12345);
      check("t5_dis_right", $signed(out_right), -777);
      repeat (10) step();
      check("t5_dis_level_held", int'(lfo_level), 0);

      // 6: async reset with a full pipeline
      shape    = 2'b00;
      depth    = 8'd255;
      rate_div = 24'd3;
      enable   = 1'b1;
      send(1000, -1000);
      step();
      send(2000, -2000);
      step();
      check("t6_pre_valid", int'(out_valid), 1);
      check("t6_pre_left", $signed(out_left), 7);
      #3 RST_N = 1'b0;
      #1;
      check("t6_async_valid", int'(out_valid), 0);
      check("t6_async_left", $signed(out_left), 0);
      check("t6_async_right", $signed(out_right), 0);
      in_valid = 1'b0;
      step();
      #2 RST_N = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         check($sformatf("t6_no_stale_e%0d", k), int'(out_valid), 0);
         check($sformatf("t6_level_e%0d", k), int'(lfo_level), 0);
      end
      step();
      check("t6_first_tick", int'(lfo_level), 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tremolo_lfo.md
Name: tremolo_lfo

Overview:
- Parametrised stereo tremolo for the audio effects chain.
- Modulates the amplitude of a left/right sample stream with an internal low-frequency oscillator (LFO).
- LFO rate, depth and shape are runtime-programmable.
- Sample path is a 2-stage valid-qualified pipeline, inserted between the audio codec receive path and downstream effects.

Parameters:
- DATA_W, 16, signed sample width for both channels.
- DIV_W, 24, width of LFO tick divider.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- enable  in  1  1 = modulate; 0 = unity gain, LFO held at phase 0.
- rate_div  in  DIV_W  LFO step period in CLK cycles minus one.
- depth  in  8  modulation depth: 0 = none, 255 = maximum.
- shape  in  2  00 triangle, 01 square, 10 saw-down, 11 triangle.
- in_valid  in  1  input sample pair valid this cycle.
- in_left  in  DATA_W  signed left sample.
- in_right  in  DATA_W  signed right sample.
- out_valid  out  1  output pair valid.
- out_left  out  DATA_W  signed modulated left sample.
- out_right  out  DATA_W  signed modulated right sample.
- lfo_level  out  8  current LFO level L (debug/metering).

Behaviour:
- Reset (RST_N low, async):
  - out_valid, out_left, out_right = 0.
  - Divider counter = 0, phase = 0.
  - Pipeline registers cleared; in-flight samples are discarded.
  - No output pulse appears after reset release.
- Divider:
  - Counter increments each cycle while enable = 1.
  - When counter >= max(rate_div, 1) - ... specifically: when counter >= rate_div, assert a 1-cycle tick and reset counter to 0.
  - rate_div = 0 gives a tick every cycle.
  - Lowering rate_div below the current count produces a tick on the next cycle.
- Phase:
  - 8-bit, increments by 1 on tick, wraps 255 -> 0.
  - enable = 0 forces counter and phase to 0 synchronously.
- LFO level L (combinational from phase and shape; lfo_level = L):
  - Triangle: phase<128 -> 2*phase; else 2*(255-phase). Range 0..254.
  - Square: phase<128 -> 255; else 0.
  - Saw-down: 255 - phase.
  - A shape change takes effect immediately; phase is not disturbed.
- Gain, 9-bit unsigned: G = 256 - ((depth * (255 - L)) >> 8). Range 2..256.
  - enable = 0 forces G = 256.
- Pipeline, 2-cycle latency, one pair per cycle, no backpressure:
  - Stage 1: on in_valid, register in_left, in_right and G (gain sampled in the in_valid cycle; both channels share it). The stage-1 valid bit follows in_valid.
  - Stage 2: out_x = (in_x * G) >>> 8, arithmetic shift, floor toward minus infinity.
    - Product width is DATA_W+10 signed.
    - Result always fits DATA_W; no saturation logic.
    - out_valid follows the stage-1 valid bit.
  - out_left and out_right hold their last value when out_valid = 0.
- Back-to-back in_valid: each pair gets its own G; no bubbles are inserted.
- depth, rate_div and shape are quasi-static control, sampled every cycle, with no handshake.

Test Plan:
1. depth=0, enable=1, in_valid 1 cycle with in_left=16'h4000, in_right=16'hC000 -> exactly 2 cycles later out_valid=1 for 1 cycle, out_left=16'h4000, out_right=16'hC000.
2. enable=1, shape=00, rate_div=3, depth=255:
   - lfo_level steps 0,2,4,... every 4 CLK; 254 at phases 127 and 128; 0 at phase 255, then wraps to 0.
   - At phase 0, in_left=1000 -> out_left=7 (G=2).
3. shape=01, depth=128:
   - Phase<128 (G=256): in_left=-32768 -> out_left=-32768.
   - Phase>=128 (G=129): in_left=-32768 -> out_left=-16512; in_left=-1 -> out_left=-1; in_left=1 -> out_left=0.
4. Streaming: in_valid held high 10 cycles with ramp 0..9 and depth=0 -> out_valid high 10 cycles starting 2 cycles later, values 0..9 in order.
5. rate_div=100; wait until counter=50, then set rate_div=5 -> tick next cycle, then every 6 cycles. With enable=0: phase=0, lfo_level=0 (triangle), outputs equal inputs.
6. Pipeline full, drop RST_N between clock edges -> out_valid and outputs 0 immediately. Release -> no stale out_valid; phase restarts at 0.
